// File: rtl/spi_xip_pkg.sv
// -----------------------------------------------------------------------------
// spi_xip_pkg
// Shared definitions for the APB-to-SPI-flash XIP bridge:
//   - xip_state_e       : bridge FSM states
//   - CSR_OFF_DIV/STATUS : CSR word offsets inside the 8-byte CSR window
//   - DEFAULT_READ_CMD  : standard serial-flash READ opcode
//   - xip_bits()        : total bits clocked per read (cmd + addr + data word)
// -----------------------------------------------------------------------------
package spi_xip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RESP  = 3'd4,
    ST_ERR   = 3'd5
  } xip_state_e;

  localparam logic [2:0] CSR_OFF_DIV    = 3'd0;
  localparam logic [2:0] CSR_OFF_STATUS = 3'd4;

  localparam logic [7:0] DEFAULT_READ_CMD = 8'h03;

  // One 32-bit word is returned per read; MOSI is don't-care during it.
  localparam int XIP_DATA_BITS = 32;

  function automatic int xip_bits(input int addr_bits);
    return 8 + addr_bits + XIP_DATA_BITS;
  endfunction

endpackage

// File: rtl/spi_xip_shifter.sv
// -----------------------------------------------------------------------------
// spi_xip_shifter
// Mode-0 (CPOL=0, CPHA=0) SPI shift engine. A start pulse loads the transmit
// word, the half-period divider D and the bit count; each bit then takes 2*D
// clocks (SCK low for D, high for D). MISO is sampled on the clock where SCK
// rises, MOSI advances on the clock where SCK falls. done_o pulses on the
// clock of the final falling edge; rx_o holds the last 32 received bits,
// first-received bit in rx_o[31].
// Ports:
//   clock, reset_n      system clock, async active-low reset
//   start_i             load and begin a transfer
//   div_i[15:0]         SCK half-period in clocks (must be >= 1)
//   load_i[W-1:0]       transmit word, MSB first
//   nbits_i[CNT_W-1:0]  number of bits to transfer
//   miso_i              serial data in
//   done_o              last bit finished this clock
//   rx_o[31:0]          received data (last 32 bits)
//   sck_o, mosi_o       SPI clock and serial data out
// -----------------------------------------------------------------------------
module spi_xip_shifter #(
  parameter int W     = 64,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [15:0]      div_i,
  input  logic [W-1:0]     load_i,
  input  logic [CNT_W-1:0] nbits_i,
  input  logic             miso_i,
  output logic             done_o,
  output logic [31:0]      rx_o,
  output logic             sck_o,
  output logic             mosi_o
);

  logic             active_q;
  logic             sck_q;
  logic [15:0]      half_q;
  logic [15:0]      div_q;
  logic [CNT_W-1:0] left_q;
  logic [W-1:0]     sh_q;
  logic [31:0]      rx_q;

  logic edge_now, rise, fall;

  assign edge_now = active_q && (half_q == div_q - 16'd1);
  assign rise     = edge_now && !sck_q;
  assign fall     = edge_now && sck_q;
  assign done_o   = fall && (left_q == CNT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      half_q   <= '0;
      div_q    <= 16'd1;
      left_q   <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      sck_q    <= 1'b0;
      half_q   <= '0;
      div_q    <= div_i;
      left_q   <= nbits_i;
    end else if (active_q) begin
      if (edge_now) begin
        half_q <= '0;
        sck_q  <= ~sck_q;
        if (fall) begin
          left_q <= left_q - CNT_W'(1);
          if (done_o) active_q <= 1'b0;
        end
      end else begin
        half_q <= half_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (start_i)   sh_q <= load_i;
    else if (fall) sh_q <= {sh_q[W-2:0], 1'b0};
    if (rise)      rx_q <= {rx_q[30:0], miso_i};
  end

  // During the load cycle the MSB is presented early so the flash sees a
  // settled first bit before the first SCK rise.
  assign mosi_o = active_q ? sh_q[W-1] : (start_i ? load_i[W-1] : 1'b0);
  assign sck_o  = sck_q;
  assign rx_o   = rx_q;

endmodule

// File: rtl/spi_flash_xip_apb.sv
// -----------------------------------------------------------------------------
// spi_flash_xip_apb
// APB slave that turns reads of the flash window into serial-flash READ
// (cmd + address + 32 data bits) transactions, plus an 8-byte CSR window:
//   +0 DIV    [15:0] SCK half-period in clocks (0 behaves as 1)
//   +4 STATUS bit0 busy, [31:16] completed flash reads (wrapping)
// Flash writes and accesses outside both windows return pslverr.
// Optional: define SPI_XIP_CACHE_EN for a single-entry read cache.
// Ports:
//   clock, reset_n                       system clock, async active-low reset
//   in_paddr/psel/penable/pwrite/pwdata  APB request (pprot, pstrb ignored)
//   in_pready/prdata/pslverr             APB response
//   spi_sck/ss/mosi/miso                 SPI flash pins (mode 0)
//   spi_busy                             SPI transaction in progress
// -----------------------------------------------------------------------------
module spi_flash_xip_apb
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
  parameter logic [31:0] CSR_BASE   = 32'h1000_1000,
  parameter int          ADDR_BITS  = 24,
  parameter logic [7:0]  READ_CMD   = DEFAULT_READ_CMD,
  parameter int          SS_NUM     = 8,
  parameter int          SS_IDX     = 0,
  parameter logic [15:0] CLK_DIV    = 16'd1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       in_paddr,
  input  logic              in_psel,
  input  logic              in_penable,
  input  logic              in_pwrite,
  input  logic [2:0]        in_pprot,
  input  logic [31:0]       in_pwdata,
  input  logic [3:0]        in_pstrb,
  output logic              in_pready,
  output logic [31:0]       in_prdata,
  output logic              in_pslverr,
  output logic              spi_sck,
  output logic [SS_NUM-1:0] spi_ss,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_busy
);

  localparam int XFER_BITS = xip_bits(ADDR_BITS);

  xip_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 flash_q;
  logic [31:0]          rdata_q;
  logic [15:0]          div_q;
  logic [15:0]          rd_cnt_q;

  logic        access, in_flash, in_csr, flash_rd, hit;
  logic [31:0] csr_off, hit_data;
  logic [2:0]  csr_word;
  logic [15:0] div_eff;
  logic        sh_done;
  logic [31:0] sh_rx;
  logic        unused_ok;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign access   = in_psel & in_penable;
  assign in_flash = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
  assign csr_off  = in_paddr - CSR_BASE;
  assign in_csr   = csr_off < 32'd8;
  assign csr_word = {csr_off[2], 2'b00};
  assign flash_rd = in_flash & ~in_pwrite;
  assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;

`ifdef SPI_XIP_CACHE_EN
  logic                 cache_vld_q;
  logic [ADDR_BITS-3:0] cache_addr_q;
  logic [31:0]          cache_data_q;

  assign hit      = cache_vld_q && (cache_addr_q == in_paddr[ADDR_BITS-1:2]);
  assign hit_data = cache_data_q;

  // Every flash response (hit or miss) rewrites the entry; a hit rewrites
  // identical contents, which keeps the refill condition trivial.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          cache_vld_q <= 1'b0;
    else if (state_q == ST_RESP && flash_q) cache_vld_q <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (state_q == ST_RESP && flash_q) begin
      cache_addr_q <= addr_q[ADDR_BITS-1:2];
      cache_data_q <= rdata_q;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (flash_rd)    state_d = hit ? ST_RESP : ST_SETUP;
          else if (in_csr) state_d = ST_RESP;
          else             state_d = ST_ERR;
        end
      end
      ST_SETUP: state_d = ST_SHIFT;
      ST_SHIFT: if (sh_done) state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      flash_q  <= 1'b0;
      div_q    <= CLK_DIV;
      rd_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && access) begin
        flash_q <= flash_rd;
        if (!in_flash && in_csr && in_pwrite && csr_word == CSR_OFF_DIV)
          div_q <= in_pwdata[15:0];
      end
      if (state_q == ST_RESP && flash_q) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == ST_IDLE && access) begin
      addr_q <= {in_paddr[ADDR_BITS-1:2], 2'b00};
      if (flash_rd)
        rdata_q <= hit_data;
      else if (in_csr && !in_pwrite)
        rdata_q <= (csr_word == CSR_OFF_STATUS) ? {rd_cnt_q, 15'd0, spi_busy}
                                                : {16'd0, div_q};
      else
        rdata_q <= '0;
    end else if (state_q == ST_HOLD) begin
      rdata_q <= bswap32(sh_rx);
    end
  end

  // D is captured by the shifter on the SETUP clock, so later DIV writes
  // cannot disturb a transfer already running.
  spi_xip_shifter #(
    .W     (XFER_BITS),
    .CNT_W (8)
  ) u_shifter (
    .clock   (clock),
    .reset_n (reset_n),
    .start_i (state_q == ST_SETUP),
    .div_i   (div_eff),
    .load_i  ({READ_CMD, addr_q, 32'h0}),
    .nbits_i (8'(XFER_BITS)),
    .miso_i  (spi_miso),
    .done_o  (sh_done),
    .rx_o    (sh_rx),
    .sck_o   (spi_sck),
    .mosi_o  (spi_mosi)
  );

  always_comb begin
    spi_ss = '1;
    if (state_q == ST_SETUP || state_q == ST_SHIFT) spi_ss[SS_IDX] = 1'b0;
  end

  assign spi_busy   = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  assign in_pready  = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign in_pslverr = (state_q == ST_ERR);
  assign in_prdata  = (state_q == ST_RESP) ? rdata_q : 32'h0;

  assign unused_ok = ^{in_pprot, in_pstrb, in_pwdata[31:16]};

endmodule

// File: tb/tb_spi_flash_xip_apb.sv
module tb_spi_flash_xip_apb;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_paddr = '0;
  logic        in_psel = 1'b0;
  logic        in_penable = 1'b0;
  logic        in_pwrite = 1'b0;
  logic [2:0]  in_pprot = '0;
  logic [31:0] in_pwdata = '0;
  logic [3:0]  in_pstrb = 4'hf;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic        spi_sck;
  logic [7:0]  spi_ss;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic        spi_busy;

  int checks = 0;
  int errors = 0;

  spi_flash_xip_apb dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_paddr   (in_paddr),
    .in_psel    (in_psel),
    .in_penable (in_penable),
    .in_pwrite  (in_pwrite),
    .in_pprot   (in_pprot),
    .in_pwdata  (in_pwdata),
    .in_pstrb   (in_pstrb),
    .in_pready  (in_pready),
    .in_prdata  (in_prdata),
    .in_pslverr (in_pslverr),
    .spi_sck    (spi_sck),
    .spi_ss     (spi_ss),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_busy   (spi_busy)
  );

  always #5 clock = ~clock;

  // ---------------- flash model (mode 0, READ 0x03) ----------------
  int          sck_rises = 0;
  int          rise_base = 0;
  int          ss_falls = 0;
  logic [31:0] cmd_addr = '0;
  int          ss_low_cyc = 0;
  int          sck_hi_cyc = 0;
  int          other_ss_low = 0;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [7:0] b;
    b = 8'(({6'd0, a[1:0]} + 8'd1) * 8'h11);
    return b ^ a[11:4];
  endfunction

  always @(negedge spi_ss[0]) begin
    rise_base = sck_rises;
    ss_falls++;
  end

  always @(posedge spi_sck) begin
    if (spi_ss[0] === 1'b0) begin
      if ((sck_rises - rise_base) < 32) cmd_addr = {cmd_addr[30:0], spi_mosi};
    end
    sck_rises++;
  end

  always @(negedge spi_sck) begin
    int k, j;
    logic [23:0] ba;
    logic [7:0]  b;
    if (spi_ss[0] === 1'b0) begin
      k = sck_rises - rise_base;
      if (k >= 32 && k < 64) begin
        j  = k - 32;
        ba = cmd_addr[23:0] + 24'(j / 8);
        b  = mem_byte(ba);
        spi_miso = b[7 - (j % 8)];
      end
    end
  end

  always @(negedge clock) begin
    if (spi_ss[0] === 1'b0) ss_low_cyc++;
    if (spi_sck === 1'b1) sck_hi_cyc++;
    if (reset_n && spi_ss[7:1] !== 7'h7f) other_ss_low++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat);
    @(posedge clock); #1;
    in_paddr = addr; in_pwrite = wr; in_pwdata = wdata;
    in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    lat = 0;
    @(negedge clock);
    while (!in_pready && lat < 2000) begin
      @(negedge clock);
      lat++;
    end
    rdata = in_prdata;
    err   = in_pslverr;
    @(posedge clock); #1;
    in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rises;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, r0, f0, s0, h0, n;

    vecs[0]  = '{32'h1000_1000, 1'b0, 32'h0,         32'h0000_0001, 1'b0, 1,   0};
    vecs[1]  = '{32'h1000_1004, 1'b0, 32'h0,         32'h0000_0000, 1'b0, 1,   0};
    vecs[2]  = '{32'h3000_0000, 1'b1, 32'hdead_beef, 32'h0000_0000, 1'b1, 1,   0};
    vecs[3]  = '{32'h2000_0000, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1,   0};
    vecs[4]  = '{32'h1000_1004, 1'b1, 32'hffff_ffff, 32'h0000_0000, 1'b0, 1,   0};
    vecs[5]  = '{32'h1000_1000, 1'b1, 32'h0000_0005, 32'h0000_0000, 1'b0, 1,   0};
    vecs[6]  = '{32'h1000_1000, 1'b0, 32'h0,         32'h0000_0005, 1'b0, 1,   0};
    vecs[7]  = '{32'h1000_1000, 1'b1, 32'habcd_0007, 32'h0000_0000, 1'b0, 1,   0};
    vecs[8]  = '{32'h1000_1000, 1'b0, 32'h0,         32'h0000_0007, 1'b0, 1,   0};
    vecs[9]  = '{32'h1000_1008, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1,   0};
    vecs[10] = '{32'h0000_0000, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1,   0};
    vecs[11] = '{32'h1000_1000, 1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0, 1,   0};
    vecs[12] = '{32'h3000_0004, 1'b0, 32'h0,         32'h4433_2211, 1'b0, 131, 64};
    vecs[13] = '{32'h1000_1004, 1'b0, 32'h0,         32'h0001_0000, 1'b0, 1,   0};
    vecs[14] = '{32'h4000_0000, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1,   0};
    vecs[15] = '{32'h3fff_fffc, 1'b0, 32'h0,         32'hbbcc_ddee, 1'b0, 131, 64};

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_pready", {31'd0, in_pready}, 32'd0);
    check("rst_prdata", in_prdata, 32'd0);
    check("rst_pslverr", {31'd0, in_pslverr}, 32'd0);
    check("rst_sck", {31'd0, spi_sck}, 32'd0);
    check("rst_ss", {24'd0, spi_ss}, 32'h0000_00ff);
    check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    check("rst_busy", {31'd0, spi_busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // table-driven CSR / error / flash vectors
    for (int i = 0; i < 16; i++) begin
      r0 = sck_rises;
      apb(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, er, lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_sck", i), 32'(sck_rises - r0), 32'(vecs[i].exp_rises));
    end
    check("v15_cmd", cmd_addr, 32'h03ff_fffc);

    // DIV=3: slower SCK, longer latency
    apb(32'h1000_1000, 1'b1, 32'd3, rd, er, lat);
    check("div3_wr_err", {31'd0, er}, 32'd0);
    s0 = ss_low_cyc; h0 = sck_hi_cyc;
    apb(32'h3000_0100, 1'b0, 32'h0, rd, er, lat);
    check("div3_rdata", rd, 32'h5423_3201);
    check("div3_lat", 32'(lat), 32'd387);
    check("div3_sck_hi", 32'(sck_hi_cyc - h0), 32'd192);
    check("div3_ss_low", 32'(ss_low_cyc - s0), 32'd385);
    check("pready_1clk", {31'd0, in_pready}, 32'd0);
    apb(32'h1000_1004, 1'b0, 32'h0, rd, er, lat);
    check("div3_status", rd, 32'h0003_0000);

    // reset mid-transfer at bit 20
    @(posedge clock); #1;
    in_paddr = 32'h3000_0004; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
    @(posedge clock); #1;
    in_penable = 1'b1;
    r0 = sck_rises; n = 0;
    while ((sck_rises - r0) < 20 && n < 1000) begin
      @(posedge clock);
      n++;
    end
    check("rst_mid_reached", {31'd0, (sck_rises - r0) >= 20}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_ss", {24'd0, spi_ss}, 32'h0000_00ff);
    check("rst_mid_sck", {31'd0, spi_sck}, 32'd0);
    check("rst_mid_busy", {31'd0, spi_busy}, 32'd0);
    check("rst_mid_pready", {31'd0, in_pready}, 32'd0);
    in_psel = 1'b0; in_penable = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    apb(32'h1000_1000, 1'b0, 32'h0, rd, er, lat);
    check("rst_div", rd, 32'h0000_0001);
    apb(32'h1000_1004, 1'b0, 32'h0, rd, er, lat);
    check("rst_status", rd, 32'h0000_0000);
    s0 = ss_low_cyc;
    apb(32'h3000_0004, 1'b0, 32'h0, rd, er, lat);
    check("post_rst_rdata", rd, 32'h4433_2211);
    check("post_rst_lat", 32'(lat), 32'd131);
    check("post_rst_cmd", cmd_addr, 32'h0300_0004);
    check("post_rst_ss_low", 32'(ss_low_cyc - s0), 32'd129);
    check("post_rst_ss_idle", {24'd0, spi_ss}, 32'h0000_00ff);
    apb(32'h1000_1004, 1'b0, 32'h0, rd, er, lat);
    check("post_rst_status", rd, 32'h0001_0000);

    // DIV=0 behaves as D=1
    apb(32'h1000_1000, 1'b1, 32'd0, rd, er, lat);
    apb(32'h1000_1000, 1'b0, 32'h0, rd, er, lat);
    check("div0_rd", rd, 32'h0000_0000);
    h0 = sck_hi_cyc;
    apb(32'h3000_0100, 1'b0, 32'h0, rd, er, lat);
    check("div0_rdata", rd, 32'h5423_3201);
    check("div0_lat", 32'(lat), 32'd131);
    check("div0_sck_hi", 32'(sck_hi_cyc - h0), 32'd64);
    apb(32'h1000_1004, 1'b0, 32'h0, rd, er, lat);
    check("div0_status", rd, 32'h0002_0000);

    // repeated read of the same word
    apb(32'h3000_0008, 1'b0, 32'h0, rd, er, lat);
    check("rep1_rdata", rd, 32'h4433_2211);
    check("rep1_lat", 32'(lat), 32'd131);
    f0 = ss_falls; r0 = sck_rises;
    apb(32'h3000_0008, 1'b0, 32'h0, rd, er, lat);
    check("rep2_rdata", rd, 32'h4433_2211);
`ifdef SPI_XIP_CACHE_EN
    check("rep2_lat", 32'(lat), 32'd1);
    check("rep2_ss_falls", 32'(ss_falls - f0), 32'd0);
    check("rep2_sck", 32'(sck_rises - r0), 32'd0);
`else
    check("rep2_lat", 32'(lat), 32'd131);
    check("rep2_ss_falls", 32'(ss_falls - f0), 32'd1);
    check("rep2_sck", 32'(sck_rises - r0), 32'd64);
`endif
    apb(32'h1000_1004, 1'b0, 32'h0, rd, er, lat);
    check("rep_status", rd, 32'h0004_0000);
    check("other_ss_never_low", 32'(other_ss_low), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_xip_apb.md
# spi_flash_xip_apb

Parametrised APB-to-SPI-flash execute-in-place (XIP) bridge. It contains its own mode-0 SPI shift engine, so reads in the flash window become standard 0x03 READ transactions with no wishbone-side SPI master and no multi-step register programming. A small CSR window provides a runtime SCK divider and status. It sits on the APB crossbar in place of the older flash/SPI-master front end.

## Interface
- FLASH_BASE, 32'h3000_0000, first byte of the XIP read window
- FLASH_END, 32'h3fff_ffff, last byte of the XIP read window
- CSR_BASE, 32'h1000_1000, CSR window base; the window is 8 bytes
- ADDR_BITS, 24, number of flash address bits sent on MOSI (16..32)
- READ_CMD, 8'h03, command byte sent first
- SS_NUM, 8, width of spi_ss
- SS_IDX, 0, slave-select line driven low for flash
- CLK_DIV, 1, reset value of the DIV CSR; SCK half-period in clocks
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- in_paddr  in  32  APB address
- in_psel, in_penable, in_pwrite  in  1  APB controls
- in_pprot  in  3  ignored
- in_pwdata  in  32  write data
- in_pstrb  in  4  ignored; CSR writes are whole-word
- in_pready  out  1  transfer done
- in_prdata  out  32  read data
- in_pslverr  out  1  error response
- spi_sck  out  1  SPI clock (CPOL=0)
- spi_ss  out  SS_NUM  active-low selects
- spi_mosi  out  1  master out
- spi_miso  in  1  master in
- spi_busy  out  1  high from SETUP through HOLD

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, RESP, ERR.
- IDLE, access phase detected (in_psel & in_penable):
  - flash read → SETUP;
  - flash write, or address in neither window → ERR;
  - CSR access → RESP, with the write applied or the read data latched.
- SETUP:
  - spi_ss[SS_IDX]=0, all other selects stay 1;
  - shift register loaded with {READ_CMD, flash address, 32 don't-care bits};
  - flash address = word-aligned in_paddr[ADDR_BITS-1:0] with bits [1:0]=0;
  - spi_mosi = MSB.
- SHIFT:
  - transfers 8+ADDR_BITS+32 bits.
  - Each bit is 2·D clocks: SCK low for D clocks, then high for D clocks.
  - spi_miso is sampled on the clock where SCK rises.
  - MOSI advances on the clock where SCK falls.
  - After the last bit, SCK returns to 0 → HOLD.
- HOLD: one clock, SS all 1 → RESP.
- RESP:
  - in_pready=1 for exactly one clock;
  - in_prdata = {B3,B2,B1,B0}, where B0 is the first received byte (little-endian);
  - → IDLE.
- ERR: in_pready=1 and in_pslverr=1 for one clock, in_prdata=0 → IDLE.
- CSR at offset 0, DIV [15:0]:
  - reads and writes are whole-word;
  - DIV=0 is treated as 1;
  - D is latched in SETUP, so a DIV write never affects a transfer in flight.
- CSR at offset 4, STATUS (read-only): bit0 = busy (always 0 when read via APB), bits[31:16] = count of completed flash reads (wraps at 16'hffff→0).
- Writes to STATUS are ignored, with pslverr=0.
- in_psel dropped mid-transfer: the transfer still completes, and the response is discarded by the APB protocol.

## Timing
- Reset values:
  - in_pready=0, in_prdata=0, in_pslverr=0;
  - spi_sck=0, spi_ss=all 1, spi_mosi=0, spi_busy=0;
  - DIV=CLK_DIV, read count=0.
- Reset assertion mid-transfer: all outputs take their reset values immediately (asynchronously), and the FSM returns to IDLE.
- Flash read latency, counted from the first access-phase clock to the in_pready clock: 3 + 2·D·(40+ADDR_BITS) clocks. With defaults (D=1, ADDR_BITS=24) this is 131.
- CSR access and error latency: in_pready in the 2nd access-phase clock.
- Access-phase cycles that arrive while not in IDLE are not accepted; only in IDLE does a new access begin.

## Configuration
- SPI_XIP_CACHE_EN defined: a single-entry cache holds {valid, word address, data}.
  - A flash read that hits goes IDLE→RESP directly, with no SPI activity and CSR-like latency.
  - A miss refills the entry in RESP.
  - A DIV write does not invalidate the entry; reset clears valid.
  - Hits are counted in STATUS bits[31:16] the same as misses.
- Not defined: every flash read performs a full SPI transaction, and no cache flops exist.

## Structure
- Package spi_xip_pkg holds:
  - FSM state enum;
  - CSR offsets (DIV=0, STATUS=4);
  - default READ_CMD;
  - bit-count helper constant function.
- Sub-module spi_xip_shifter: SCK divider, bit counter, MOSI/MISO shift register. Its interface is start, D, load word, bit count, done, rx word.
- The top level holds the APB decode, FSM, CSRs and the optional cache.

## Test plan
- Defaults; APB read of 0x3000_0004, flash model holding 0x11,0x22,0x33,0x44 at 0x000004 → MOSI carries 0x03,0x00,0x00,0x04; prdata=0x44332211; pready at clock 131; SS[0] low only during the transfer.
- Write DIV=3, then read 0x3000_0100 → SCK period 6 clocks; latency 3+384=387; read count becomes 1.
- APB write to 0x3000_0000, and a read of 0x2000_0000 → pslverr=1, pready in the 2nd access clock, no SCK toggles.
- reset_n pulsed low at bit 20 of SHIFT → SS=all 1 and SCK=0 in the same cycle; the next read completes normally.
- DIV written to 0 → behaves as D=1; a STATUS read returns count in bits[31:16] and bit0=0.
- With SPI_XIP_CACHE_EN, two reads of 0x3000_0008 → the first takes 131 clocks; the second has pready in the 2nd clock with identical data and no SS activity.
